pe_flit_injector: RTL and testbench
===================================

PE_FLIT_INJECTOR -- requirements
Module: pe_flit_injector

Interface
REQ-001 Parameter DATA_W, 32, payload bits per flit.
REQ-002 Parameter DEST_BITS, 4, destination port ID width.
REQ-003 Parameter VC_BITS, 1, virtual-channel index width; NUM_VC = 2**VC_BITS.
REQ-004 Parameter BUF_DEPTH, 8, initial credits per VC, equal to the router input buffer depth per VC.
REQ-005 Parameter LEN_W, 4, packet length field width.
REQ-006 Derived widths: FLIT_W = 2+DEST_BITS+VC_BITS+DATA_W; CRED_W = 1+VC_BITS; CNT_W = clog2(BUF_DEPTH+1).
REQ-007 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 cmd_valid / cmd_ready  in / out  1 / 1  packet command handshake.
REQ-011 cmd_dest, cmd_vc, cmd_len  in  DEST_BITS, VC_BITS, LEN_W  destination, VC, flit count.
REQ-012 data_valid / data_ready  in / out  1 / 1  payload stream handshake, one word per flit.
REQ-013 data_in  in  DATA_W  payload word.
REQ-014 flit_out  out  FLIT_W  {valid, tail, dest, vc, data}, MSB first.
REQ-015 send_flit  out  1  network putFlit enable.
REQ-016 credit_in  in  CRED_W  {valid, vc}, from network getCredits.
REQ-017 en_recv_credit  in  1  qualifies credit_in.
REQ-018 busy  out  1  high while not IDLE.
REQ-019 pkt_count  out  16  packets fully sent, wraps modulo 2^16.
REQ-020 credit_err  out  1  sticky credit-overflow flag.

Function
REQ-021 FSM states: IDLE and SEND; cmd_ready = (state==IDLE).
REQ-022 IDLE with cmd_valid and cmd_len != 0: latch dest, vc, and rem=cmd_len; go to SEND next cycle.
REQ-023 IDLE with cmd_valid and cmd_len == 0: consume the command; emit no flit; stay IDLE; pkt_count unchanged.
REQ-024 data_ready = (state==SEND) && (credit[vc_latched] != 0).
REQ-025 Flit handshake when data_valid && data_ready: next cycle send_flit=1 and flit_out={1, rem==1, dest, vc, data_in}; decrement rem.
REQ-026 Latency from payload handshake to send_flit is exactly 1 cycle.
REQ-027 Cycles without a handshake: send_flit=0 and flit_out=0.
REQ-028 Tail flit handshake (rem==1): return to IDLE next cycle; increment pkt_count when the tail is sent.
REQ-029 Back-to-back packets: a new command is accepted in the cycle after SEND exits, so there is a minimum 1-cycle gap between packets.
REQ-030 Credit counters: one per VC, CNT_W bits.
REQ-031 A credit return is the event en_recv_credit && credit_in[CRED_W-1]; it increments credit[credit_in vc].
REQ-032 Each flit handshake decrements credit[vc_latched].
REQ-033 Return and consume on the same VC in the same cycle: counter unchanged.
REQ-034 Return and consume on different VCs in the same cycle: each applied independently.
REQ-035 A credit return to a counter already at BUF_DEPTH (not offset by a same-cycle consume) saturates the counter and sets credit_err, which is held until reset.
REQ-036 en_recv_credit with valid bit 0 is ignored.
REQ-037 Credit 0 on the active VC: data_ready stays low and the packet stalls mid-stream; no flit is sent without credit.

Reset
REQ-038 In the rst cycle: state=IDLE, all credits=BUF_DEPTH, send_flit=0, flit_out=0, pkt_count=0, credit_err=0, busy=0, rem=0.
REQ-039 rst mid-packet aborts the packet with no tail emitted; returns received during rst are discarded.

Verification
REQ-040 Single packet: cmd dest=3 vc=0 len=3, data valid every cycle -> 3 consecutive send_flit pulses, tail only on the 3rd; credit[0]=5; pkt_count=1.
REQ-041 Credit exhaustion: len=10 on vc=1 with no returns -> 8 flits, then stall; one credit return on vc=1 -> 9th flit 2 cycles later.
REQ-042 Simultaneous return and consume on vc 0 for 4 cycles at credit 8 -> credit[0] stays 8 and credit_err stays 0.
REQ-043 Overflow: credit return on vc 0 right after reset -> credit_err=1 and credit[0]=8.
REQ-044 Zero-length command -> cmd_ready high, no send_flit, pkt_count=0; then len=1 -> single flit with tail=1.
REQ-045 rst asserted after 2 of 5 flits -> busy=0, credits=8/8; a fresh len=2 packet then sends correctly.

Source files
------------

// File: rtl/pe_flit_injector.sv
// ---------------------------------------------------------------------------
// pe_flit_injector
//   Packetises a payload stream into NoC flits for one processing element.
//   A command (dest, vc, len) opens a packet; each accepted payload word
//   becomes one flit, registered so it appears exactly one cycle after the
//   payload handshake. Per-VC credit counters gate the payload stream so no
//   flit leaves without buffer space in the downstream router.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o packet command handshake
//   cmd_dest_i/vc_i/len_i   destination, virtual channel, flit count
//   data_valid_i/ready_o    payload handshake, one word per flit
//   data_in_i               payload word
//   flit_out_o              {valid, tail, dest, vc, data}, zero when idle
//   send_flit_o             network putFlit enable
//   credit_in_i             {valid, vc} credit return from the network
//   en_recv_credit_i        qualifies credit_in_i
//   busy_o                  high while a packet is open
//   pkt_count_o             packets completed, wraps at 2^16
//   credit_err_o            sticky: credit returned to a full counter
// ---------------------------------------------------------------------------

// One credit counter per VC. Consume is only ever asserted while the count
// is non-zero (data_ready is gated on it), so no underflow guard is needed.
module pe_credit_ctr #(
    parameter int BUF_DEPTH = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ret_i,
    input  logic             cons_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        // A simultaneous return and consume cancel, even when full.
        if (ret_i && !cons_i) begin
            if (cnt_q == FULL) ovf_o = 1'b1;
            else               cnt_d = cnt_q + CNT_W'(1);
        end else if (cons_i && !ret_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= FULL;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module pe_flit_injector #(
    parameter int  DATA_W    = 32,
    parameter int  DEST_BITS = 4,
    parameter int  VC_BITS   = 1,
    parameter int  BUF_DEPTH = 8,
    parameter int  LEN_W     = 4,
    localparam int NUM_VC    = 2**VC_BITS,
    localparam int FLIT_W    = 2 + DEST_BITS + VC_BITS + DATA_W,
    localparam int CRED_W    = 1 + VC_BITS,
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [DEST_BITS-1:0] cmd_dest_i,
    input  logic [VC_BITS-1:0]   cmd_vc_i,
    input  logic [LEN_W-1:0]     cmd_len_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    input  logic [DATA_W-1:0]    data_in_i,
    output logic [FLIT_W-1:0]    flit_out_o,
    output logic                 send_flit_o,
    input  logic [CRED_W-1:0]    credit_in_i,
    input  logic                 en_recv_credit_i,
    output logic                 busy_o,
    output logic [15:0]          pkt_count_o,
    output logic                 credit_err_o
);
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    typedef struct packed {
        logic                 vld;
        logic                 tail;
        logic [DEST_BITS-1:0] dest;
        logic [VC_BITS-1:0]   vc;
        logic [DATA_W-1:0]    data;
    } flit_t;

    state_t               state_q, state_d;
    logic [DEST_BITS-1:0] dest_q, dest_d;
    logic [VC_BITS-1:0]   vc_q, vc_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    flit_t                flit_q, flit_d;
    logic                 send_q, send_d;
    logic [15:0]          pkt_q, pkt_d;
    logic                 err_q;

    logic [NUM_VC-1:0][CNT_W-1:0] credit_w;
    logic [NUM_VC-1:0]            ret_vec, cons_vec, ovf_vec;
    logic                         crd_evt, hs;

    // ---------------- credit tracking ----------------
    assign crd_evt = en_recv_credit_i && credit_in_i[CRED_W-1];

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign ret_vec[v]  = crd_evt && (credit_in_i[VC_BITS-1:0] == VC_BITS'(v));
        assign cons_vec[v] = hs && (vc_q == VC_BITS'(v));

        pe_credit_ctr #(
            .BUF_DEPTH (BUF_DEPTH),
            .CNT_W     (CNT_W)
        ) u_ctr (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .ret_i  (ret_vec[v]),
            .cons_i (cons_vec[v]),
            .cnt_o  (credit_w[v]),
            .ovf_o  (ovf_vec[v])
        );
    end

    // ---------------- handshakes ----------------
    assign cmd_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q == SEND);
    assign data_ready_o = (state_q == SEND) && (credit_w[vc_q] != '0);
    assign hs           = data_valid_i && data_ready_o;

    // ---------------- FSM / datapath next state ----------------
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        vc_d    = vc_q;
        rem_d   = rem_q;
        flit_d  = '0;
        send_d  = 1'b0;
        pkt_d   = pkt_q;

        unique case (state_q)
            IDLE: begin
                // Zero-length commands are accepted and dropped here.
                if (cmd_valid_i && (cmd_len_i != '0)) begin
                    dest_d  = cmd_dest_i;
                    vc_d    = cmd_vc_i;
                    rem_d   = cmd_len_i;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    send_d      = 1'b1;
                    flit_d.vld  = 1'b1;
                    flit_d.tail = (rem_q == LEN_W'(1));
                    flit_d.dest = dest_q;
                    flit_d.vc   = vc_q;
                    flit_d.data = data_in_i;
                    rem_d       = rem_q - LEN_W'(1);
                    // Count lands on the same edge the tail flit is registered.
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        pkt_d   = pkt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dest_q  <= '0;
            vc_q    <= '0;
            rem_q   <= '0;
            flit_q  <= '0;
            send_q  <= 1'b0;
            pkt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            vc_q    <= vc_d;
            rem_q   <= rem_d;
            flit_q  <= flit_d;
            send_q  <= send_d;
            pkt_q   <= pkt_d;
            if (|ovf_vec) err_q <= 1'b1;
        end
    end

    assign flit_out_o   = flit_q;
    assign send_flit_o  = send_q;
    assign pkt_count_o  = pkt_q;
    assign credit_err_o = err_q;
endmodule

// File: tb/tb_pe_flit_injector.sv
// ---------------------------------------------------------------------------
// tb_pe_flit_injector
//   Scenario tasks drive commands, payload and credit returns. Every accepted
//   payload word pushes its expected flit onto a queue; a negedge monitor pops
//   and compares whenever send_flit is seen, and checks flit_out is zero
//   otherwise. Credit state is observed through the DUT's credit_w vector.
// ---------------------------------------------------------------------------
module tb_pe_flit_injector;
    localparam int DATA_W = 32, DEST_BITS = 4, VC_BITS = 1, LEN_W = 4;
    localparam int FLIT_W = 2 + DEST_BITS + VC_BITS + DATA_W;
    localparam int CRED_W = 1 + VC_BITS;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid = 1'b0, cmd_ready;
    logic [DEST_BITS-1:0] cmd_dest = '0;
    logic [VC_BITS-1:0]   cmd_vc = '0;
    logic [LEN_W-1:0]     cmd_len = '0;
    logic                 data_valid = 1'b0, data_ready;
    logic [DATA_W-1:0]    data_in = '0;
    logic [FLIT_W-1:0]    flit_out;
    logic                 send_flit;
    logic [CRED_W-1:0]    credit_in = '0;
    logic                 en_recv_credit = 1'b0;
    logic                 busy;
    logic [15:0]          pkt_count;
    logic                 credit_err;

    always #5 clk = ~clk;

    pe_flit_injector dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_dest_i       (cmd_dest),
        .cmd_vc_i         (cmd_vc),
        .cmd_len_i        (cmd_len),
        .data_valid_i     (data_valid),
        .data_ready_o     (data_ready),
        .data_in_i        (data_in),
        .flit_out_o       (flit_out),
        .send_flit_o      (send_flit),
        .credit_in_i      (credit_in),
        .en_recv_credit_i (en_recv_credit),
        .busy_o           (busy),
        .pkt_count_o      (pkt_count),
        .credit_err_o     (credit_err)
    );

    int checks = 0;
    int errors = 0;

    logic [FLIT_W-1:0]    exp_q[$];
    logic [FLIT_W-1:0]    mon_exp;
    bit                   mon_en = 1'b0;
    logic [DEST_BITS-1:0] cur_dest;
    logic [VC_BITS-1:0]   cur_vc;
    int                   cur_rem;
    int                   word_ctr = 0;

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (send_flit === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL flit_unexpected got %h required none", flit_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (flit_out !== mon_exp) begin
                        errors++;
                        $display("FAIL flit_data got %h required %h", flit_out, mon_exp);
                    end
                end
            end else if (send_flit !== 1'b0 || flit_out !== '0) begin
                errors++;
                $display("FAIL idle_flit got send=%b flit=%h required 0/0", send_flit, flit_out);
            end
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic apply_reset();
        rst = 1'b1; cmd_valid = 1'b0; data_valid = 1'b0; en_recv_credit = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_cmd(input logic [DEST_BITS-1:0] d, input logic [VC_BITS-1:0] v,
                          input logic [LEN_W-1:0] len);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_idle got %b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_dest = d; cmd_vc = v; cmd_len = len;
        @(negedge clk);
        cmd_valid = 1'b0;
        cur_dest = d; cur_vc = v; cur_rem = int'(len);
        if (len != '0) begin
            checks++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL cmd_accept got busy=%b ready=%b required 1/0", busy, cmd_ready);
            end
        end
    endtask

    // Offer n payload words; optionally return a credit on the packet VC in
    // every handshake cycle. cyc reports cycles taken.
    task automatic stream(input int n, input bit ret, output int cyc);
        int sent;
        sent = 0; cyc = 0;
        data_valid = 1'b1;
        while (sent < n && cyc < 64) begin
            data_in = 32'hA500_0000 + 32'(word_ctr);
            en_recv_credit = 1'b0;
            if (data_ready === 1'b1) begin
                exp_q.push_back({1'b1, (cur_rem == 1), cur_dest, cur_vc, data_in});
                cur_rem--; sent++; word_ctr++;
                if (ret) begin en_recv_credit = 1'b1; credit_in = {1'b1, cur_vc}; end
            end
            @(negedge clk);
            cyc++;
        end
        data_valid = 1'b0; en_recv_credit = 1'b0;
        checks++;
        if (sent != n) begin
            errors++; $display("FAIL stream_timeout got %0d flits required %0d", sent, n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        en_recv_credit = 1'b1; credit_in = 2'b10;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b required 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        checks++; if (send_flit !== 1'b0 || flit_out !== '0) begin errors++; $display("FAIL reset_flit got %b/%h required 0/0", send_flit, flit_out); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt got %0d required 0", pkt_count); end
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b required 0", credit_err); end
        checks++; if (dut.credit_w[0] !== 4'd8 || dut.credit_w[1] !== 4'd8) begin errors++; $display("FAIL reset_credits got %0d/%0d required 8/8", dut.credit_w[0], dut.credit_w[1]); end
        checks++; if (dut.rem_q !== 4'd0) begin errors++; $display("FAIL reset_rem got %0d required 0", dut.rem_q); end
        en_recv_credit = 1'b0;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        int cyc;
        apply_reset();
        do_cmd(4'd3, 1'b0, 4'd3);
        stream(3, 1'b0, cyc);
        checks++; if (cyc != 3) begin errors++; $display("FAIL single_consecutive got %0d cycles required 3", cyc); end
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL single_pkt got %0d required 1", pkt_count); end
        checks++; if (dut.credit_w[0] !== 4'd5) begin errors++; $display("FAIL single_credit0 got %0d required 5", dut.credit_w[0]); end
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got ready=%b busy=%b required 1/0", cmd_ready, busy); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        apply_reset();
        do_cmd(4'd5, 1'b1, 4'd2);
        stream(2, 1'b0, cyc);
        do_cmd(4'd6, 1'b0, 4'd1);   // ready again right after the tail cycle
        stream(1, 1'b0, cyc);
        checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL b2b_pkt got %0d required 2", pkt_count); end
        checks++; if (dut.credit_w[0] !== 4'd7 || dut.credit_w[1] !== 4'd6) begin errors++; $display("FAIL b2b_credits got %0d/%0d required 7/6", dut.credit_w[0], dut.credit_w[1]); end
    endtask

    task automatic test_exhaust();
        int cyc;
        apply_reset();
        do_cmd(4'd9, 1'b1, 4'd10);
        stream(8, 1'b0, cyc);
        checks++; if (dut.credit_w[1] !== 4'd0) begin errors++; $display("FAIL exh_credit_zero got %0d required 0", dut.credit_w[1]); end
        // Hold payload valid: the stream must stall.
        data_valid = 1'b1; data_in = 32'hA500_0000 + 32'(word_ctr);
        for (int i = 0; i < 3; i++) begin
            checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL exh_stall got %b required 0", data_ready); end
            @(negedge clk);
        end
        // A return with valid=0 must be ignored.
        en_recv_credit = 1'b1; credit_in = 2'b01;
        @(negedge clk);
        checks++; if (dut.credit_w[1] !== 4'd0 || data_ready !== 1'b0) begin errors++; $display("FAIL exh_invalid_ret got %0d/%b required 0/0", dut.credit_w[1], data_ready); end
        // One real credit: 9th flit two cycles later.
        credit_in = 2'b11;
        @(negedge clk);
        en_recv_credit = 1'b0;
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL exh_ready_after_ret got %b required 1", data_ready); end
        exp_q.push_back({1'b1, (cur_rem == 1), cur_dest, cur_vc, data_in});
        cur_rem--; word_ctr++;
        @(negedge clk);
        data_valid = 1'b0;
        checks++; if (send_flit !== 1'b1) begin errors++; $display("FAIL exh_9th_latency got %b required 1", send_flit); end
        // Finish the packet with one more credit.
        en_recv_credit = 1'b1; credit_in = 2'b11;
        @(negedge clk);
        en_recv_credit = 1'b0;
        stream(1, 1'b0, cyc);
        checks++; if (pkt_count !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL exh_done got pkt=%0d busy=%b required 1/0", pkt_count, busy); end
        checks++; if (dut.credit_w[1] !== 4'd0) begin errors++; $display("FAIL exh_credit_end got %0d required 0", dut.credit_w[1]); end
    endtask

    task automatic test_simul();
        int cyc;
        apply_reset();
        do_cmd(4'd1, 1'b0, 4'd4);
        stream(4, 1'b1, cyc);
        checks++; if (dut.credit_w[0] !== 4'd8) begin errors++; $display("FAIL simul_credit got %0d required 8", dut.credit_w[0]); end
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL simul_err got %b required 0", credit_err); end
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL simul_pkt got %0d required 1", pkt_count); end
    endtask

    task automatic test_overflow();
        apply_reset();
        en_recv_credit = 1'b1; credit_in = 2'b00;   // invalid, ignored
        @(negedge clk);
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL ovf_invalid got %b required 0", credit_err); end
        credit_in = 2'b10;
        @(negedge clk);
        en_recv_credit = 1'b0;
        checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b required 1", credit_err); end
        checks++; if (dut.credit_w[0] !== 4'd8) begin errors++; $display("FAIL ovf_sat got %0d required 8", dut.credit_w[0]); end
        repeat (2) @(negedge clk);
        checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b required 1", credit_err); end
        apply_reset();
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b required 0", credit_err); end
    endtask

    task automatic test_zero_len();
        int cyc;
        apply_reset();
        do_cmd(4'd2, 1'b0, 4'd0);
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zlen_idle got ready=%b busy=%b required 1/0", cmd_ready, busy); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL zlen_pkt got %0d required 0", pkt_count); end
        do_cmd(4'd2, 1'b0, 4'd1);
        stream(1, 1'b0, cyc);
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL zlen_one_pkt got %0d required 1", pkt_count); end
    endtask

    task automatic test_rst_mid();
        int cyc;
        apply_reset();
        do_cmd(4'd4, 1'b0, 4'd5);
        stream(2, 1'b0, cyc);
        @(negedge clk);
        rst = 1'b1;
        en_recv_credit = 1'b1; credit_in = 2'b11;  // would overflow vc1 if honoured
        @(negedge clk);
        rst = 1'b0; en_recv_credit = 1'b0;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_idle got busy=%b ready=%b required 0/1", busy, cmd_ready); end
        checks++; if (dut.credit_w[0] !== 4'd8 || dut.credit_w[1] !== 4'd8) begin errors++; $display("FAIL rmid_credits got %0d/%0d required 8/8", dut.credit_w[0], dut.credit_w[1]); end
        checks++; if (credit_err !== 1'b0 || pkt_count !== 16'd0) begin errors++; $display("FAIL rmid_state got err=%b pkt=%0d required 0/0", credit_err, pkt_count); end
        do_cmd(4'd7, 1'b1, 4'd2);
        stream(2, 1'b0, cyc);
        checks++; if (pkt_count !== 16'd1 || dut.credit_w[1] !== 4'd6) begin errors++; $display("FAIL rmid_fresh got pkt=%0d cr1=%0d required 1/6", pkt_count, dut.credit_w[1]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_exhaust();
        test_simul();
        test_overflow();
        test_zero_len();
        test_rst_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
